// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bubble encoding, reset PC default, IF/ID bundle.
// The IF/ID bundle type is also consumed by the decode stage.
package cpu_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned ILEN      = 32;
    localparam int unsigned CNT_W_DEF = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 64'h0;
    localparam logic [ILEN-1:0] NOP_INSTR_DEF = 32'h8B1F_03FF;  // ADD XZR,XZR,XZR

    // IF/ID pipeline register payload
    typedef struct packed {
        logic            valid;
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } ifid_t;

    // Reset/idle contents of the IF/ID register
    function automatic ifid_t ifid_reset_val(input logic [ILEN-1:0] nop);
        ifid_t r;
        r.valid    = 1'b0;
        r.instr    = nop;
        r.pc       = '0;
        r.pc_plus4 = '0;
        return r;
    endfunction

endpackage

// File: rtl/big_adder64.sv
// 64-bit adder with carry in/out.
// Ports: a_i, b_i operands; cin_i carry in; sum_o 64-bit sum; cout_o carry out.
module Big_adder64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        cin_i,
    output logic [63:0] sum_o,
    output logic        cout_o
);

    assign {cout_o, sum_o} = 65'(a_i) + 65'(b_i) + 65'(cin_i);

endmodule

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID bundle register with priority reset > flush > hold(stall) > load.
// Ports: clk; reset sync active-high; flush_i insert bubble (pc fields hold);
//        stall_i hold contents; load_i bundle captured otherwise; q_o contents.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  flush_i,
    input  logic  stall_i,
    input  ifid_t load_i,
    output ifid_t q_o
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    // Next-contents selection
    always_comb begin
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
        end else if (!stall_i) begin
            ifid_d = load_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_q <= ifid_reset_val(NOP_INSTR);
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q_o = ifid_q;

endmodule

// File: rtl/reg64_en.sv
// 64-bit register with load enable, no reset of its own (reset is applied
// through d_i with the enable forced high by the owner).
// Ports: clk; en_i load enable; d_i next value; q_o current value.
module reg64_en (
    input  logic        clk,
    input  logic        en_i,
    input  logic [63:0] d_i,
    output logic [63:0] q_o
);

    logic [63:0] q_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem address, fills IF/ID.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall                 hold PC and IF/ID this cycle
//   redirect_valid/_pc    taken branch: load target, flush IF/ID
//   imem_addr/imem_instr  combinational instruction memory interface
//   ifid_*                IF/ID register contents for decode
//   misalign_err          sticky flag for a redirect target with bits[1:0] != 0
//   fetch_count           instructions captured into IF/ID
//   flush_count           redirects accepted
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [63:0]      redirect_pc,
    output logic [63:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    output logic             ifid_valid,
    output logic [31:0]      ifid_instr,
    output logic [63:0]      ifid_pc,
    output logic [63:0]      ifid_pc_plus4,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic        pc_en;
    logic [63:0] pc_plus4;
    logic        pc_plus4_cout_unused;

    logic             capture;
    logic             misalign_q;
    logic             misalign_d;
    logic [CNT_W-1:0] fetch_count_q;
    logic [CNT_W-1:0] fetch_count_d;
    logic [CNT_W-1:0] flush_count_q;
    logic [CNT_W-1:0] flush_count_d;

    ifid_t ifid_load;
    ifid_t ifid_q;

    // Sequential PC + 4; carry out is discarded so the PC wraps mod 2^64
    Big_adder64 u_pc_adder (
        .a_i    (pc_q),
        .b_i    (64'd4),
        .cin_i  (1'b0),
        .sum_o  (pc_plus4),
        .cout_o (pc_plus4_cout_unused)
    );

    // Next-PC: reset > redirect (word-aligned) > stall (enable low) > +4
    always_comb begin
        pc_en = ~stall | redirect_valid | reset;
        pc_d  = pc_plus4;
        if (reset) begin
            pc_d = RESET_PC;
        end else if (redirect_valid) begin
            pc_d = {redirect_pc[63:2], 2'b00};
        end
    end

    reg64_en u_pc_reg (
        .clk  (clk),
        .en_i (pc_en),
        .d_i  (pc_d),
        .q_o  (pc_q)
    );

    assign imem_addr = pc_q;

    // Bundle offered to IF/ID on a capture cycle
    always_comb begin
        ifid_load.valid    = 1'b1;
        ifid_load.instr    = imem_instr;
        ifid_load.pc       = pc_q;
        ifid_load.pc_plus4 = pc_plus4;
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .stall_i (stall),
        .load_i  (ifid_load),
        .q_o     (ifid_q)
    );

    assign ifid_valid    = ifid_q.valid;
    assign ifid_instr    = ifid_q.instr;
    assign ifid_pc       = ifid_q.pc;
    assign ifid_pc_plus4 = ifid_q.pc_plus4;

    // Sticky misalignment flag and event counters
    always_comb begin
        capture       = ~redirect_valid & ~stall;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (redirect_valid) begin
            flush_count_d = flush_count_q + CNT_W'(1);
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end
        if (capture) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver pushes the expected post-edge
// snapshot from a behavioural model; a monitor pops and compares after each edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h8B1F_03FF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [63:0] ifid_pc;
    logic [63:0] ifid_pc_plus4;
    logic        misalign_err;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] pc4;
        logic        mis;
        logic [31:0] fcnt;
        logic [31:0] flcnt;
    } snap_t;

    snap_t exp_q[$];

    // Reference model state
    logic [63:0] m_pc;
    snap_t       m;

    always #5 clk = ~clk;

    // Instruction memory: word depends on the address
    assign imem_instr = 32'hAAAA_0000 + imem_addr[31:0];

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count),
        .flush_count    (flush_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and record what the outputs must be after the edge
    task automatic step(input logic rst, input logic st, input logic rv, input logic [63:0] rpc);
        @(negedge clk);
        reset          = rst;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rst) begin
            m_pc    = 64'h0;
            m.valid = 1'b0;
            m.instr = NOP;
            m.pc    = 64'h0;
            m.pc4   = 64'h0;
            m.mis   = 1'b0;
            m.fcnt  = 0;
            m.flcnt = 0;
        end else if (rv) begin
            m.valid = 1'b0;
            m.instr = NOP;
            m.mis   = m.mis | (rpc % 4 != 0);
            m.flcnt = m.flcnt + 1;
            m_pc    = rpc - (rpc % 4);
        end else if (!st) begin
            m.valid = 1'b1;
            m.instr = 32'hAAAA_0000 + m_pc[31:0];
            m.pc    = m_pc;
            m.pc4   = m_pc + 64'd4;
            m.fcnt  = m.fcnt + 1;
            m_pc    = m_pc + 64'd4;
        end
        m.addr = m_pc;
        exp_q.push_back(m);
    endtask

    // Monitor: compare the DUT against the oldest expectation after each edge
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_addr",     imem_addr,     e.addr);
                chk("ifid_valid",    64'(ifid_valid), 64'(e.valid));
                chk("ifid_instr",    64'(ifid_instr), 64'(e.instr));
                chk("ifid_pc",       ifid_pc,       e.pc);
                chk("ifid_pc_plus4", ifid_pc_plus4, e.pc4);
                chk("misalign_err",  64'(misalign_err), 64'(e.mis));
                chk("fetch_count",   64'(fetch_count),  64'(e.fcnt));
                chk("flush_count",   64'(flush_count),  64'(e.flcnt));
            end
        end
    end

    initial begin
        logic [63:0] rpc;
        m_pc = 64'h0;
        m    = '{default: '0};

        // Reset two cycles, then free-run fetch from 0
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b0, 1'b0, 1'b0, 64'h0);
        step(1'b0, 1'b0, 1'b0, 64'h0);
        // Stall two cycles at pc 8, then release
        step(1'b0, 1'b1, 1'b0, 64'h0);
        step(1'b0, 1'b1, 1'b0, 64'h0);
        step(1'b0, 1'b0, 1'b0, 64'h0);
        // Redirect during stall at pc 12
        step(1'b0, 1'b1, 1'b1, 64'h100);
        step(1'b0, 1'b0, 1'b0, 64'h0);
        // Back-to-back redirects
        step(1'b0, 1'b0, 1'b1, 64'h40);
        step(1'b0, 1'b0, 1'b1, 64'h80);
        step(1'b0, 1'b0, 1'b0, 64'h0);
        // Misaligned target sets the sticky flag
        step(1'b0, 1'b0, 1'b1, 64'h103);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 64'h0);
        // Wrap at the top of the address space
        step(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 64'h0);
        // Reset mid-stall and mid-redirect
        step(1'b1, 1'b1, 1'b1, 64'h203);
        step(1'b0, 1'b0, 1'b0, 64'h0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = {$urandom(), $urandom()};
                1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: rpc = 64'($urandom_range(0, 4095));
            endcase
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
                 rpc);
        end
        step(1'b0, 1'b0, 1'b0, 64'h0);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
